decrypt_iter_top: RTL and testbench
===================================

# decrypt_iter_top

Iterative AES-128 inverse cipher (FIPS-197 §5.3) that turns one 128-bit ciphertext block into plaintext, one round per clock. It is the decryption counterpart of the encryption datapath and takes the same externally expanded round keys. Blocks are accepted with a start/done handshake.

## Interface
Parameters: none (AES-128 only, Nr = 10).

- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE
- cipher_text  input  128  ciphertext block, sampled on the accepted start edge
- round0_key … round10_key  input  128 each  expanded key schedule; round0_key is the cipher key
- plain_text  output  128  registered result; reset 0; holds until the next done
- busy  output  1  high from accept edge through the FINAL edge; reset 0
- done  output  1  one-cycle pulse when plain_text updates; reset 0

## Operation
- Byte order: state byte 0 = bits [127:120]; bytes fill columns first (FIPS-197 input mapping).
- Registers: 128-bit state, 4-bit round_cnt, FSM {IDLE, ROUND, FINAL}.
- IDLE: if start, state <= cipher_text ^ round10_key, round_cnt <= 9, busy <= 1, go ROUND. Otherwise hold.
- ROUND, one edge per round r = round_cnt: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_r_key). If round_cnt == 1, go FINAL. Otherwise round_cnt <= round_cnt − 1.
- FINAL: plain_text <= InvSubBytes(InvShiftRows(state)) ^ round0_key, done <= 1, busy <= 0, go IDLE.
- InvShiftRows: row i rotates right by i bytes.
- InvSubBytes: 16 parallel combinational inverse S-box lookups.
- InvMixColumns: per column, multiply by the matrix {0e,0b,0d,09} over GF(2^8) with reduction polynomial 0x11B. xtime-based, no multipliers.
- Round keys are read live in the cycle they are used. The source must hold them stable from start until done. cipher_text need not be held after the accept edge.
- start while busy is ignored. No queuing and no error flag.

## Timing
- Accept edge E0. Rounds 9..1 occur on E1..E9. FINAL occurs on E10.
- done is high for exactly the cycle after E10. plain_text is valid from E10 onward.
- Latency: 10 clocks from accept edge to result.
- busy rises after E0 and falls after E10, in the same cycle done rises.
- A start during the done cycle is accepted at E11, giving a minimum spacing of 11 clocks per block.
- start held high continuously re-accepts every 11 clocks.
- Reset asserted at any point, including mid-round or in the done cycle:
  - plain_text, busy, done, state and round_cnt go to 0 immediately.
  - The FSM goes to IDLE and the in-flight block is discarded with no done.
  - The first start after reset deassertion is accepted normally.

## Test plan
Round keys are generated by the bench key-expansion model.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a -> plain_text 00112233445566778899aabbccddeeff. done pulses exactly 10 clocks after the accept edge; busy is high for exactly 10 cycles.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, cipher_text 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- All-zero key, cipher_text 66e94bd4ef8a2c3b884cfa59ca342b2e -> plain_text 0. Then start in the done cycle with the C.1 ciphertext -> accepted at E11, correct result 10 clocks later.
- Start pulses at E3 and E7 while busy, with a different cipher_text each time -> ignored; the result matches the first block only.
- Reset asserted between E5 and E6 -> outputs are 0 asynchronously and no done follows. A new start after release produces the correct C.1 result.
- Stress: 1000 random key/plaintext pairs encrypted by the bench model, then decrypted -> every plain_text matches, with no done outside the expected cycles.

Source files
------------

// File: rtl/decrypt_iter_top.sv
// Iterative AES-128 inverse cipher: one round per clock, 10 clocks from the
// accepting start edge to a one-cycle done pulse with the plaintext.
// Round keys come from an external key schedule and are read live each cycle.
`timescale 1ns/1ps
module decrypt_iter_top (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] cipher_text,
    input  logic [127:0] round0_key,
    input  logic [127:0] round1_key,
    input  logic [127:0] round2_key,
    input  logic [127:0] round3_key,
    input  logic [127:0] round4_key,
    input  logic [127:0] round5_key,
    input  logic [127:0] round6_key,
    input  logic [127:0] round7_key,
    input  logic [127:0] round8_key,
    input  logic [127:0] round9_key,
    input  logic [127:0] round10_key,
    output logic [127:0] plain_text,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte i of a block lives at bits [127-8i -: 8]; byte index = 4*column + row.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant below 16 as a sum of a, 2a, 4a, 8a (xtime chain only).
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

    // Circulant row {0e,0b,0d,09}: coefficient depends on (input row - output row) mod 4.
    function automatic logic [3:0] inv_coef(input int idx);
        case (idx)
            0:       return 4'he;
            1:       return 4'hb;
            2:       return 4'hd;
            default: return 4'h9;
        endcase
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc ^= gf_mul_const(s[127-8*(4*c+k) -: 8], inv_coef((k-r+4)%4));
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    fsm_t         fsm, fsm_next;
    logic [127:0] state;
    logic [3:0]   round_cnt;
    logic [127:0] round_key;
    logic [127:0] inv_sub_out;
    logic [127:0] round_out;
    logic [127:0] final_out;

    // Select the key for the round currently being undone.
    always_comb begin
        // NOTE: default assignment first so every path drives round_key; no latch.
        round_key = '0;
        case (round_cnt)
            4'd1:    round_key = round1_key;
            4'd2:    round_key = round2_key;
            4'd3:    round_key = round3_key;
            4'd4:    round_key = round4_key;
            4'd5:    round_key = round5_key;
            4'd6:    round_key = round6_key;
            4'd7:    round_key = round7_key;
            4'd8:    round_key = round8_key;
            4'd9:    round_key = round9_key;
            default: round_key = '0;
        endcase
    end

    // Shared round datapath: full inverse round, and the last round without InvMixColumns.
    always_comb begin
        inv_sub_out = inv_sub_bytes(inv_shift_rows(state));
        round_out   = inv_mix_columns(inv_sub_out ^ round_key);
        final_out   = inv_sub_out ^ round0_key;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments for all clocked state avoid read/write races.
        if (reset) fsm <= IDLE;
        else       fsm <= fsm_next;
    end

    // FSM next-state logic.
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (start) fsm_next = ROUND;
            ROUND:   if (round_cnt == 4'd1) fsm_next = FINAL;
            FINAL:   fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // FSM outputs: busy spans every cycle the block is in flight.
    always_comb begin
        busy = (fsm != IDLE);
    end

    // Datapath registers: load, per-round update, and final result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= '0;
            round_cnt  <= '0;
            plain_text <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: if (start) begin
                    state     <= cipher_text ^ round10_key;
                    round_cnt <= 4'd9;
                end
                ROUND: begin
                    state <= round_out;
                    if (round_cnt != 4'd1) round_cnt <= round_cnt - 4'd1;
                end
                FINAL: begin
                    plain_text <= final_out;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt_iter_top.sv
// Self-checking bench for decrypt_iter_top. Ciphertexts are produced by a
// forward AES-128 model (S-box derived from GF(2^8) inversion + affine map),
// so the expected plaintext is simply the block that was encrypted.
`timescale 1ns/1ps
module tb_decrypt_iter_top;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] cipher_text;
    logic [127:0] rk [11];
    logic [127:0] plain_text;
    logic         busy;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] sbox [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    decrypt_iter_top dut (
        .clk(clk), .reset(reset), .start(start), .cipher_text(cipher_text),
        .round0_key(rk[0]), .round1_key(rk[1]), .round2_key(rk[2]), .round3_key(rk[3]),
        .round4_key(rk[4]), .round5_key(rk[5]), .round6_key(rk[6]), .round7_key(rk[7]),
        .round8_key(rk[8]), .round9_key(rk[9]), .round10_key(rk[10]),
        .plain_text(plain_text), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %032h expected %032h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Forward cipher over the currently loaded schedule.
    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   m [4];
        logic [127:0] blk;
        m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        blk = pt ^ rk[0];
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int i = 0; i < 16; i++) t[i] = s[i];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        s[4*c+row] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            s[4*c+row] ^= gmul(t[4*c+k], m[(k-row+4)%4]);
                    end
            end
            for (int i = 0; i < 16; i++) s[i] ^= rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
        return blk;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge (the accept edge E0) and check the block went busy.
    task automatic accept(input logic [127:0] ct);
        cipher_text = ct;
        start = 1'b1;
        tick();
        start = 1'b0;
        cipher_text = rand128();
        check("accept_busy", 128'(busy), 128'(1));
        check("accept_done", 128'(done), 128'(0));
    endtask

    // Walk edges E1..E10; done only after E10, busy through E9; optional stray starts at E3/E7.
    task automatic rounds(input string tag, input logic [127:0] exp_pt, input bit stray);
        for (int k = 1; k <= 10; k++) begin
            if (stray && (k == 3 || k == 7)) begin
                start = 1'b1;
                cipher_text = rand128();
            end else begin
                start = 1'b0;
            end
            tick();
            check({tag, "_busy"}, 128'(busy), 128'(k < 10));
            check({tag, "_done"}, 128'(done), 128'(k == 10));
            if (k == 10) check({tag, "_pt"}, plain_text, exp_pt);
        end
        start = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        tick();
        check({tag, "_idle_busy"}, 128'(busy), 128'(0));
        check({tag, "_idle_done"}, 128'(done), 128'(0));
    endtask

    initial begin
        logic [127:0] pt, ct;
        reset = 1'b1;
        start = 1'b0;
        cipher_text = '0;
        for (int r = 0; r < 11; r++) rk[r] = '0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        check("rst_pt", plain_text, 128'h0);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        #3 reset = 1'b0;
        idle_check("post_rst");

        // FIPS-197 C.1
        set_key(C1_KEY);
        accept(C1_CT);
        rounds("c1", C1_PT, 1'b0);
        idle_check("c1");
        check("c1_hold", plain_text, C1_PT);

        // FIPS-197 Appendix B
        set_key(B_KEY);
        accept(B_CT);
        rounds("appb", B_PT, 1'b0);
        idle_check("appb");

        // All-zero key, then a start in the done cycle (accepted at E11)
        set_key(128'h0);
        accept(Z_CT);
        rounds("zero", 128'h0, 1'b0);
        set_key(C1_KEY);
        accept(C1_CT);
        rounds("chain", C1_PT, 1'b0);
        idle_check("chain");

        // Starts while busy are ignored
        set_key(B_KEY);
        accept(B_CT);
        rounds("stray", B_PT, 1'b1);
        idle_check("stray");

        // Reset between E5 and E6 discards the block
        set_key(C1_KEY);
        accept(C1_CT);
        for (int k = 1; k <= 5; k++) tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_pt", plain_text, 128'h0);
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        @(posedge clk);
        #3 reset = 1'b0;
        for (int k = 0; k < 12; k++) idle_check("midrst");
        accept(C1_CT);
        rounds("after_rst", C1_PT, 1'b0);
        idle_check("after_rst");

        // Random stress: encrypt with the model, decrypt with the DUT
        for (int n = 0; n < 1000; n++) begin
            set_key(rand128());
            pt = rand128();
            ct = aes_encrypt(pt);
            accept(ct);
            rounds("rand", pt, n[0]);
            repeat ($urandom_range(0, 2)) idle_check("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
